// File: rtl/coco_intc.sv
// coco_intc: fixed-priority interrupt controller for up to 8 device IRQ lines.
// Drives one CPU request and runs a request / acknowledge / EOI handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request outstanding; arbitrate eligible sources
// REQ     | IRQ_O high, waiting for ACK_I on the latched INT_ID
// SERVICE | CPU is servicing INT_ID; wait for an EOI write to STATUS
module coco_intc #(
    parameter int N = 6
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [3:2]    ADD_I,
    input  logic          WE_I,
    input  logic [31:0]   DAT_I,
    input  logic [3:0]    BE,
    output logic [31:0]   DAT_O,
    input  logic [N-1:0]  HWINT_I,
    input  logic          ACK_I,
    output logic          IRQ_O,
    output logic [2:0]    INT_ID
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t         r_state;
    logic [2:0]     r_int_id;
    logic           r_irq;
    logic [N-1:0]   r_mask;
    logic [N-1:0]   r_mode;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   r_prev;

    logic [N-1:0]   w_elig;
    logic [2:0]     w_winner;
    logic           w_cur_elig;
    logic [N-1:0]   w_id_oh;
    logic           w_ack_take;
    logic           w_wr_lo;
    logic           w_eoi;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_rise;
    logic [N-1:0]   w_pend_next;
    logic           w_unused;

    // Registers are at most 8 bits wide, so only byte lane 0 carries data.
    assign w_unused = ^{DAT_I[31:N], BE[3:1]};

    assign w_elig     = r_pend & r_mask;
    assign w_ack_take = (r_state == ST_REQ) && ACK_I;
    assign w_wr_lo    = WE_I && BE[0];
    assign w_eoi      = WE_I && (ADD_I == 2'd3);

    always_comb begin
        w_winner   = '0;
        w_cur_elig = 1'b0;
        w_id_oh    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_elig[i]) w_winner = 3'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (r_int_id == 3'(i)) begin
                w_cur_elig = w_elig[i];
                w_id_oh[i] = 1'b1;
            end
        end
    end

    // Edge sources: a new rising edge beats any same-cycle clear.
    assign w_rise      = HWINT_I & ~r_prev;
    assign w_clr       = ((w_wr_lo && (ADD_I == 2'd1)) ? DAT_I[N-1:0] : '0)
                       | (w_ack_take ? w_id_oh : '0);
    assign w_pend_next = (r_mode & (w_rise | (r_pend & ~w_clr)))
                       | (~r_mode & HWINT_I);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_mask <= '0;
            r_mode <= '0;
            r_pend <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= HWINT_I;
            r_pend <= w_pend_next;
            if (w_wr_lo && (ADD_I == 2'd0)) r_mask <= DAT_I[N-1:0];
            if (w_wr_lo && (ADD_I == 2'd2)) r_mode <= DAT_I[N-1:0];
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state  <= ST_IDLE;
            r_int_id <= '0;
            r_irq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_state  <= ST_REQ;
                        r_int_id <= w_winner;
                        r_irq    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ACK_I) begin
                        r_state <= ST_SERVICE;
                        r_irq   <= 1'b0;
                    end else if (!w_cur_elig) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_eoi) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (ADD_I)
            2'd0:    DAT_O = {{(32 - N){1'b0}}, r_mask};
            2'd1:    DAT_O = {{(32 - N){1'b0}}, r_pend};
            2'd2:    DAT_O = {{(32 - N){1'b0}}, r_mode};
            default: DAT_O = {27'b0, r_state, r_int_id};
        endcase
    end

    assign IRQ_O  = r_irq;
    assign INT_ID = r_int_id;

endmodule

// File: tb/tb_coco_intc.sv
// Bench for coco_intc: register vector table, handshake sequences, then
// randomized traffic checked every cycle against a behavioural model.
module tb_coco_intc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  add = 2'd0;
    logic        we  = 1'b0;
    logic [31:0] dat = '0;
    logic [3:0]  be  = '0;
    logic [31:0] dat_o;
    logic [5:0]  hw  = '0;
    logic        ack = 1'b0;
    logic        irq;
    logic [2:0]  id;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    logic [5:0] m_mask = '0, m_mode = '0, m_pend = '0, m_prev = '0;
    int         m_state = 0;
    int         m_id = 0;

    coco_intc #(.N(6)) dut (
        .CLK_I(clk), .RST_I(rst), .ADD_I(add), .WE_I(we), .DAT_I(dat),
        .BE(be), .DAT_O(dat_o), .HWINT_I(hw), .ACK_I(ack),
        .IRQ_O(irq), .INT_ID(id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  add;
        logic [31:0] dat;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {26'b0, m_mask};
            2'd1:    return {26'b0, m_pend};
            2'd2:    return {26'b0, m_mode};
            default: return 32'(m_state * 8 + m_id);
        endcase
    endfunction

    // One clock: predict from current inputs, advance, then compare.
    task automatic cyc();
        logic [5:0] n_mask, n_mode, n_pend, elig;
        int         n_state, n_id;
        logic       taken, clr;
        n_mask  = m_mask;
        n_mode  = m_mode;
        n_state = m_state;
        n_id    = m_id;
        elig    = m_pend & m_mask;
        taken   = (m_state == 1) && ack;
        if (we && be[0] && add == 2'd0) n_mask = dat[5:0];
        if (we && be[0] && add == 2'd2) n_mode = dat[5:0];
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) begin
                clr = (we && be[0] && add == 2'd1 && dat[i]) || (taken && m_id == i);
                n_pend[i] = (hw[i] && !m_prev[i]) || (m_pend[i] && !clr);
            end else begin
                n_pend[i] = hw[i];
            end
        end
        if (m_state == 0) begin
            if (elig != 0) begin
                n_state = 1;
                for (int i = 5; i >= 0; i--) if (elig[i]) n_id = i;
            end
        end else if (m_state == 1) begin
            if (ack) n_state = 2;
            else if (!elig[m_id]) n_state = 0;
        end else begin
            if (we && add == 2'd3) n_state = 0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
            m_state = 0; m_id = 0;
        end else begin
            m_mask = n_mask; m_mode = n_mode; m_pend = n_pend; m_prev = hw;
            m_state = n_state; m_id = n_id;
        end
        chk("model_irq", {31'b0, irq}, {31'b0, m_state == 1});
        chk("model_int_id", {29'b0, id}, 32'(m_id));
        chk("model_dat_o", dat_o, m_read(add));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        add = a; dat = d; be = b; we = 1'b1;
        cyc();
        we = 1'b0; be = '0; dat = '0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        we  = 1'b0;
        add = a;
        #1;
        chk(name, dat_o, exp);
    endtask

    task automatic ack_cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 4'hF, 32'h3F};
        vecs[1] = '{2'd0, 32'h0000_0015, 4'h0, 32'h3F};
        vecs[2] = '{2'd0, 32'h0000_0012, 4'h2, 32'h3F};
        vecs[3] = '{2'd0, 32'h0000_0000, 4'h1, 32'h00};
        vecs[4] = '{2'd2, 32'h0000_00A5, 4'h1, 32'h25};
        vecs[5] = '{2'd2, 32'h0000_0000, 4'hE, 32'h25};
        vecs[6] = '{2'd2, 32'h0000_0000, 4'h1, 32'h00};
        vecs[7] = '{2'd1, 32'hFFFF_FFFF, 4'hF, 32'h00};

        // 1: reset state
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        rd_chk("rst_mask", 2'd0, 32'h0);
        rd_chk("rst_pend", 2'd1, 32'h0);
        rd_chk("rst_mode", 2'd2, 32'h0);
        rd_chk("rst_status", 2'd3, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);

        for (int v = 0; v < 8; v++) begin
            wr(vecs[v].add, vecs[v].dat, vecs[v].be);
            rd_chk($sformatf("vec%0d", v), vecs[v].add, vecs[v].exp);
        end

        // 2: single edge source, latency and handshake
        wr(2'd0, 32'h3F, 4'h1);
        wr(2'd2, 32'h01, 4'h1);
        hw = 6'h01;
        cyc();
        hw = 6'h00;
        rd_chk("t2_pend_k1", 2'd1, 32'h01);
        chk("t2_irq_k1", {31'b0, irq}, 32'h0);
        cyc();
        chk("t2_irq_k2", {31'b0, irq}, 32'h1);
        chk("t2_id_k2", {29'b0, id}, 32'h0);
        ack_cyc();
        rd_chk("t2_status_svc", 2'd3, 32'h10);
        rd_chk("t2_pend_ack", 2'd1, 32'h00);
        wr(2'd3, 32'h0, 4'hF);
        rd_chk("t2_status_eoi", 2'd3, 32'h00);

        // 3: two edge sources together, priority order
        wr(2'd2, 32'h09, 4'h1);
        wr(2'd0, 32'h09, 4'h1);
        hw = 6'h09;
        cyc();
        hw = 6'h00;
        cyc();
        chk("t3_irq_first", {31'b0, irq}, 32'h1);
        chk("t3_id_first", {29'b0, id}, 32'h0);
        rd_chk("t3_pend_both", 2'd1, 32'h09);
        ack_cyc();
        wr(2'd3, 32'h0, 4'h0);
        cyc();
        chk("t3_irq_second", {31'b0, irq}, 32'h1);
        chk("t3_id_second", {29'b0, id}, 32'h3);
        ack_cyc();
        wr(2'd3, 32'h0, 4'hF);

        // 4: level source
        wr(2'd2, 32'h00, 4'h1);
        wr(2'd0, 32'h04, 4'h1);
        hw = 6'h04;
        cyc(); cyc();
        chk("t4_irq_req", {31'b0, irq}, 32'h1);
        chk("t4_id_req", {29'b0, id}, 32'h2);
        wr(2'd1, 32'h04, 4'h1);
        rd_chk("t4_pend_w1c", 2'd1, 32'h04);
        ack_cyc();
        wr(2'd3, 32'h0, 4'hF);
        cyc();
        chk("t4_irq_reassert", {31'b0, irq}, 32'h1);
        hw = 6'h00;
        cyc(); cyc();
        chk("t4_irq_drop", {31'b0, irq}, 32'h0);
        rd_chk("t4_state_drop", 2'd3, 32'h02);

        // 5: mask withdrawn while in REQ
        wr(2'd2, 32'h02, 4'h1);
        wr(2'd0, 32'h02, 4'h1);
        hw = 6'h02;
        cyc();
        hw = 6'h00;
        cyc();
        chk("t5_id_req", {29'b0, id}, 32'h1);
        wr(2'd0, 32'h00, 4'h1);
        cyc();
        chk("t5_irq_masked", {31'b0, irq}, 32'h0);
        rd_chk("t5_pend_kept", 2'd1, 32'h02);
        rd_chk("t5_status_idle", 2'd3, 32'h01);
        wr(2'd0, 32'h02, 4'h1);
        cyc();
        chk("t5_irq_again", {31'b0, irq}, 32'h1);
        chk("t5_id_again", {29'b0, id}, 32'h1);
        ack_cyc();
        wr(2'd3, 32'h0, 4'hF);

        // 6: reset during SERVICE with the line held high
        wr(2'd2, 32'h01, 4'h1);
        wr(2'd0, 32'h01, 4'h1);
        hw = 6'h01;
        cyc(); cyc();
        ack_cyc();
        rd_chk("t6_status_svc", 2'd3, 32'h10);
        rst = 1'b1; ack = 1'b1; we = 1'b1; add = 2'd0; dat = 32'hFF; be = 4'hF;
        cyc();
        rst = 1'b0; ack = 1'b0; we = 1'b0; dat = '0; be = '0;
        rd_chk("t6_mask", 2'd0, 32'h0);
        rd_chk("t6_pend", 2'd1, 32'h0);
        rd_chk("t6_mode", 2'd2, 32'h0);
        rd_chk("t6_status", 2'd3, 32'h0);
        chk("t6_irq", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h01, 4'h1);
        wr(2'd1, 32'h01, 4'h1);
        cyc();
        rd_chk("t6_no_edge", 2'd1, 32'h0);
        hw = 6'h00;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 7) == 0) hw[b] = ~hw[b];
            ack = ($urandom_range(0, 3) == 0);
            we  = ($urandom_range(0, 4) == 0);
            add = 2'($urandom_range(0, 3));
            dat = $urandom;
            be  = 4'($urandom_range(0, 15));
            cyc();
        end
        rst = 1'b0; ack = 1'b0; we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
